exe_issue_ctrl: RTL and testbench

Issue and hazard controller sitting between DEC and EXE. Tracks pending register write-backs in a 16-entry scoreboard, and stalls DEC on read-after-write (RAW) and write-after-write (WAW) hazards. Sequences branch resolution by holding issue for one cycle while EXE evaluates `z_flag`, then flushing DEC and redirecting PC when the branch is taken. Also drives the EXE-stage valid bit and a saturating stall counter for performance debug.

---
 rtl/exe_issue_ctrl.sv | 105 ++++++++++
 tb/tb_exe_issue_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_issue_ctrl.sv
// Issue/hazard controller between DEC and EXE: 16-entry write-back scoreboard, branch hold/flush
// sequencing and a saturating stall counter. Optional same-cycle WB bypass: EXE_ISSUE_CTRL_BYPASS_EN.
module exe_issue_ctrl #(
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   dec_valid,
   input  logic [3:0]             dec_rs1,
   input  logic [3:0]             dec_rs2,
   input  logic                   dec_uses_rs2,
   input  logic [3:0]             dec_rd,
   input  logic                   dec_needs_wb,
   input  logic                   dec_is_branch,
   input  logic                   z_flag,
   input  logic                   wb_valid,
   input  logic [3:0]             wb_addr,
   output logic                   issue,
   output logic                   stall_dec,
   output logic                   exe_valid,
   output logic                   flush,
   output logic                   pc_sel,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int unsigned NREG = 16;

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_BR_WAIT = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [NREG-1:0]        pending_q, pending_d;
   logic                   exe_valid_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [NREG-1:0]        retire_mask;
   logic [NREG-1:0]        busy;
   logic                   raw, waw, hazard;

   assign retire_mask = wb_valid ? (NREG'(1) << wb_addr) : '0;

   // Scoreboard view used for hazard detection; bypass hides the register retiring this cycle
`ifdef EXE_ISSUE_CTRL_BYPASS_EN
   assign busy = pending_q & ~retire_mask;
`else
   assign busy = pending_q;
`endif

   assign raw    = busy[dec_rs1] | (dec_uses_rs2 & busy[dec_rs2]);
   assign waw    = dec_needs_wb & busy[dec_rd];
   assign hazard = raw | waw;

   always_comb begin
      state_d   = state_q;
      issue     = 1'b0;
      stall_dec = 1'b0;
      flush     = 1'b0;
      pc_sel    = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_RUN: begin
               issue     = dec_valid & ~hazard;
               stall_dec = dec_valid & hazard;
               if (issue && dec_is_branch) state_d = ST_BR_WAIT;
            end
            ST_BR_WAIT: begin
               stall_dec = 1'b1;
               flush     = z_flag;
               pc_sel    = z_flag;
               state_d   = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Clear on retire, then set on issue so a same-cycle set wins
   always_comb begin
      pending_d = pending_q & ~retire_mask;
      if (issue && dec_needs_wb) pending_d = pending_d | (NREG'(1) << dec_rd);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_dec && (stall_cnt_q != {STALL_CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         pending_q   <= '0;
         exe_valid_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         exe_valid_q <= issue;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign exe_valid = exe_valid_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Self-checking bench for exe_issue_ctrl: directed steps plus randomized traffic against a
// behavioural scoreboard model. Counter width reduced so saturation is reached quickly.
module tb_exe_issue_ctrl;

   localparam int unsigned W = 10;
   localparam int CNT_MAX = (1 << W) - 1;
`ifdef EXE_ISSUE_CTRL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic dec_valid, dec_uses_rs2, dec_needs_wb, dec_is_branch, z_flag, wb_valid;
   logic [3:0] dec_rs1, dec_rs2, dec_rd, wb_addr;
   logic issue, stall_dec, exe_valid, flush, pc_sel;
   logic [W-1:0] stall_cnt;

   exe_issue_ctrl #(.STALL_CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_uses_rs2(dec_uses_rs2),
      .dec_rd(dec_rd), .dec_needs_wb(dec_needs_wb), .dec_is_branch(dec_is_branch),
      .z_flag(z_flag), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .issue(issue), .stall_dec(stall_dec), .exe_valid(exe_valid),
      .flush(flush), .pc_sel(pc_sel), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state
   bit m_pend [16];
   bit m_br;
   bit m_exv;
   int m_cnt;
   bit e_issue, e_stall, e_flush, e_pcsel;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input bit dv, input int rs1, input int rs2, input bit u2, input int rd,
                         input bit nwb, input bit br, input bit z, input bit wv, input int wa);
      dec_valid = dv; dec_rs1 = 4'(rs1); dec_rs2 = 4'(rs2); dec_uses_rs2 = u2;
      dec_rd = 4'(rd); dec_needs_wb = nwb; dec_is_branch = br; z_flag = z;
      wb_valid = wv; wb_addr = 4'(wa);
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic bit busy(input int x);
      return m_pend[x] && !(BYP && wb_valid && (int'(wb_addr) == x));
   endfunction

   function automatic void model_comb();
      bit hz;
      hz = busy(int'(dec_rs1)) || (dec_uses_rs2 && busy(int'(dec_rs2))) ||
           (dec_needs_wb && busy(int'(dec_rd)));
      e_issue = rst_n && !m_br && dec_valid && !hz;
      e_stall = rst_n && (m_br || (dec_valid && hz));
      e_flush = rst_n && m_br && z_flag;
      e_pcsel = e_flush;
   endfunction

   function automatic void model_clear();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_br = 0; m_exv = 0; m_cnt = 0;
   endfunction

   // One clock: check combinational outputs, advance model on the edge, check registered outputs
   task automatic tick();
      bit nbr;
      #1;
      model_comb();
      check("issue", 32'(issue), 32'(e_issue));
      check("stall_dec", 32'(stall_dec), 32'(e_stall));
      check("flush", 32'(flush), 32'(e_flush));
      check("pc_sel", 32'(pc_sel), 32'(e_pcsel));
      nbr = e_issue && dec_is_branch;
      if (wb_valid) m_pend[int'(wb_addr)] = 1'b0;
      if (e_issue && dec_needs_wb) m_pend[int'(dec_rd)] = 1'b1;
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      m_exv = e_issue;
      m_br = nbr;
      @(posedge clk);
      #1;
      check("exe_valid", 32'(exe_valid), 32'(m_exv));
      check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      check("rst_issue", 32'(issue), 32'd0);
      check("rst_stall", 32'(stall_dec), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_pc_sel", 32'(pc_sel), 32'd0);
      check("rst_exe_valid", 32'(exe_valid), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      idle();
      @(negedge clk);
      do_reset();

      // Independent instruction issues immediately; r5 becomes pending
      set_in(1, 3, 4, 1, 5, 1, 0, 0, 0, 0);
      tick();
      check("first_exe_valid", 32'(exe_valid), 32'd1);

      // RAW on r5, producer retires three cycles later
      for (int k = 0; k < 3; k++) begin
         set_in(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      set_in(1, 5, 0, 0, 0, 0, 0, 0, 1, 5);
      tick();
      if (!BYP) begin
         set_in(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      check("raw_stall_total", 32'(stall_cnt), BYP ? 32'd3 : 32'd4);
      idle();
      tick();

      // Taken branch: one bubble, flush and redirect for exactly one cycle
      set_in(1, 1, 2, 1, 0, 0, 1, 0, 0, 0);
      tick();
      set_in(1, 8, 9, 1, 10, 1, 0, 1, 0, 0);
      tick();
      check("taken_exe_valid", 32'(exe_valid), 32'd0);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();

      // Not-taken branch: DEC instruction issues the following cycle
      set_in(1, 1, 2, 1, 0, 0, 1, 0, 0, 0);
      tick();
      set_in(1, 8, 9, 1, 10, 1, 0, 0, 0, 0);
      tick();
      tick();
      check("nt_issue_exe_valid", 32'(exe_valid), 32'd1);

      // Same-cycle retire of r7 and new write to r7
      set_in(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
      tick();
      set_in(1, 0, 0, 0, 7, 1, 0, 0, 1, 7);
      tick();
      if (!BYP) begin
         set_in(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
         tick();
      end
      set_in(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check("r7_still_pending", 32'(stall_dec), 32'd1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 10);
      tick();

      // Reset while in BR_WAIT with r4..r7 pending
      for (int r = 4; r < 8; r++) begin
         set_in(1, 0, 0, 0, r, 1, 0, 0, 0, 0);
         tick();
      end
      set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      set_in(1, 4, 5, 1, 6, 1, 0, 1, 0, 0);
      do_reset();
      set_in(1, 4, 5, 1, 6, 1, 0, 1, 0, 0);
      tick();
      check("post_rst_issue_exe", 32'(exe_valid), 32'd1);
      idle();
      do_reset();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom), $urandom_range(0, 15), 1'($urandom),
                $urandom_range(0, 7) == 0, 1'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 15));
         tick();
      end
      idle();
      do_reset();

      // Stall counter saturation under a held hazard
      set_in(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      tick();
      set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < CNT_MAX + 60; n++) tick();
      check("stall_cnt_saturated", 32'(stall_cnt), 32'(CNT_MAX));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
